// File: rtl/disp_pkg.sv
// disp_pkg: shared state encoding, digit-select table and small helpers
// for the multiplexed seven-segment display scheduler.
package disp_pkg;

    // Display ownership: live data, message hold, one-frame cool-down.
    typedef enum logic [1:0] {
        LIVE = 2'd0,
        SHOW = 2'd1,
        COOL = 2'd2
    } disp_state_t;

    // Active-low anode pattern for each scan position 0..3.
    localparam logic [3:0] DIG_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Pick the nibble of a packed 4-digit frame for scan position sel.
    function automatic logic [3:0] nibble_sel(input logic [15:0] frame,
                                              input logic [1:0]  sel);
        return frame[{sel, 2'b00} +: 4];
    endfunction

    // Ceiling log2, used to size counters from integer parameters.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 32'sd0;
        v = value - 32'sd1;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v / 32'sd2;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-cycle scan enable every CLK_HZ/SCAN_HZ clocks. The first
// pulse appears CLK_HZ/SCAN_HZ cycles after reset release, so a tick can
// never coincide with the release itself.
module tick_gen
    import disp_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic ck,
    input  logic R,
    output logic en
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (clog2(DIV) < 32'sd1) ? 32'sd1 : clog2(DIV);

    logic [CNT_W-1:0] cnt_r;
    logic             en_r;

    // Divider: count 0..DIV-1 and register a pulse on wrap.
    always_ff @(posedge ck or negedge R) begin
        if (!R) begin
            cnt_r <= {CNT_W{1'b0}};
            en_r  <= 1'b0;
        end else if (cnt_r == CNT_W'(DIV - 32'sd1)) begin
            cnt_r <= {CNT_W{1'b0}};
            en_r  <= 1'b1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
            en_r  <= 1'b0;
        end
    end

    assign en = en_r;

endmodule

// File: rtl/disp_scheduler.sv
// disp_scheduler: shares the 4-digit multiplexed display between a live
// source and a one-shot message. The frame register only changes at a
// frame boundary (tick while the last digit is selected), so a shown
// frame never tears. A granted message holds the display for HOLD_FRAMES
// frames, followed by one forced live frame before another grant.
// Optional build macro DISP_BLINK_EN: blanks the anodes on odd blink
// phases (BLINK_FRAMES frames each) while a message is shown.
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int HOLD_MS      = 2000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic        ck,
    input  logic        R,
    input  logic [15:0] live_val,
    input  logic        msg_req,
    input  logic [15:0] msg_val,
    output logic        msg_gnt,
    output logic        msg_done,
    output logic        src,
    output logic [3:0]  Dig,
    output logic [3:0]  k
);

    localparam int HOLD_FRAMES = HOLD_MS * SCAN_HZ / 32'sd4000;
    localparam int FL_W = (clog2(HOLD_FRAMES) < 32'sd1) ? 32'sd1 : clog2(HOLD_FRAMES);

    logic              en_s;
    logic              fb_s;
    logic              blank_s;
    logic [1:0]        sel_r;
    logic [15:0]       frame_r;
    logic [15:0]       frame_nxt_s;
    disp_state_t       state_r;
    disp_state_t       state_nxt_s;
    logic [FL_W-1:0]   frames_left_r;
    logic [FL_W-1:0]   frames_left_nxt_s;
    logic              msg_gnt_r;
    logic              msg_done_r;
    logic              gnt_nxt_s;
    logic              done_nxt_s;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) u_tick (
        .ck (ck),
        .R  (R),
        .en (en_s)
    );

    assign fb_s = en_s && (sel_r == 2'd3);

    // Scan position: advance one digit per tick, wrapping 3 -> 0.
    always_ff @(posedge ck or negedge R) begin
        if (!R) begin
            sel_r <= 2'd0;
        end else if (en_s) begin
            sel_r <= sel_r + 2'd1;
        end else begin
            sel_r <= sel_r;
        end
    end

    // Next-state and frame update; only a frame boundary can change anything.
    always_comb begin
        state_nxt_s       = state_r;
        frames_left_nxt_s = frames_left_r;
        frame_nxt_s       = frame_r;
        gnt_nxt_s         = 1'b0;
        done_nxt_s        = 1'b0;
        if (fb_s) begin
            case (state_r)
                LIVE: begin
                    if (msg_req) begin
                        frame_nxt_s       = msg_val;
                        frames_left_nxt_s = FL_W'(HOLD_FRAMES - 32'sd1);
                        state_nxt_s       = SHOW;
                        gnt_nxt_s         = 1'b1;
                    end else begin
                        frame_nxt_s = live_val;
                    end
                end
                SHOW: begin
                    if (frames_left_r == {FL_W{1'b0}}) begin
                        frame_nxt_s = live_val;
                        state_nxt_s = COOL;
                        done_nxt_s  = 1'b1;
                    end else begin
                        frames_left_nxt_s = frames_left_r - FL_W'(1'b1);
                    end
                end
                COOL: begin
                    frame_nxt_s = live_val;
                    state_nxt_s = LIVE;
                end
                default: begin
                    frame_nxt_s = live_val;
                    state_nxt_s = LIVE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, frame and handshake pulse registers.
    always_ff @(posedge ck or negedge R) begin
        if (!R) begin
            state_r       <= LIVE;
            frames_left_r <= {FL_W{1'b0}};
            frame_r       <= 16'h0000;
            msg_gnt_r     <= 1'b0;
            msg_done_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            frames_left_r <= frames_left_nxt_s;
            frame_r       <= frame_nxt_s;
            msg_gnt_r     <= gnt_nxt_s;
            msg_done_r    <= done_nxt_s;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BL_W = (clog2(BLINK_FRAMES) < 32'sd1) ? 32'sd1 : clog2(BLINK_FRAMES);

    logic [BL_W-1:0] blink_cnt_r;
    logic [BL_W-1:0] blink_cnt_nxt_s;
    logic            blink_odd_r;
    logic            blink_odd_nxt_s;

    // Blink phase: restart on grant, step once per elapsed message frame.
    always_comb begin
        blink_cnt_nxt_s = blink_cnt_r;
        blink_odd_nxt_s = blink_odd_r;
        if (fb_s && (state_r == LIVE) && msg_req) begin
            blink_cnt_nxt_s = {BL_W{1'b0}};
            blink_odd_nxt_s = 1'b0;
        end else if (fb_s && (state_r == SHOW) && (frames_left_r != {FL_W{1'b0}})) begin
            if (blink_cnt_r == BL_W'(BLINK_FRAMES - 32'sd1)) begin
                blink_cnt_nxt_s = {BL_W{1'b0}};
                blink_odd_nxt_s = ~blink_odd_r;
            end else begin
                blink_cnt_nxt_s = blink_cnt_r + BL_W'(1'b1);
            end
        end else begin
            blink_cnt_nxt_s = blink_cnt_r;
        end
    end

    // Blink phase registers.
    always_ff @(posedge ck or negedge R) begin
        if (!R) begin
            blink_cnt_r <= {BL_W{1'b0}};
            blink_odd_r <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_nxt_s;
            blink_odd_r <= blink_odd_nxt_s;
        end
    end

    assign blank_s = (state_r == SHOW) && blink_odd_r;
`else
    // BLINK_FRAMES has no function when blinking is compiled out.
    logic unused_blink_s;
    assign unused_blink_s = (BLINK_FRAMES > 32'sd0);
    assign blank_s        = 1'b0;
`endif

    assign Dig      = blank_s ? 4'b1111 : DIG_SEL[sel_r];
    assign k        = nibble_sel(frame_r, sel_r);
    assign src      = (state_r == SHOW);
    assign msg_gnt  = msg_gnt_r;
    assign msg_done = msg_done_r;

endmodule
